// File: rtl/lfsr_seq_ctrl_if.sv
// rtl/lfsr_seq_ctrl_if.sv - control request/status and bit-stream signals of the LFSR sequencer
interface lfsr_seq_ctrl_if #(
  parameter int LENGTH = 8,
  parameter int CNT_W  = 16
);
  logic              start;
  logic              abort;
  logic [LENGTH-1:0] seed;
  logic [CNT_W-1:0]  num_bits;
  logic              out_bit;
  logic              out_valid;
  logic              busy;
  logic              done;
  logic              seed_fixed;

  modport master (
    output start, abort, seed, num_bits,
    input  out_bit, out_valid, busy, done, seed_fixed
  );

  modport slave (
    input  start, abort, seed, num_bits,
    output out_bit, out_valid, busy, done, seed_fixed
  );
endinterface

// File: rtl/lfsr_seq_ctrl.sv
// rtl/lfsr_seq_ctrl.sv - seeds a free-running shift register, closes Fibonacci feedback, streams its MSB
module lfsr_seq_ctrl #(
  parameter int                LENGTH = 8,
  parameter logic [LENGTH-1:0] TAPS   = 8'hB8,
  parameter int                CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  lfsr_seq_ctrl_if.slave    ctl,
  input  logic [LENGTH-1:0] sr_state,
  output logic              sr_d
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  localparam logic [CNT_W-1:0] LOAD_LAST = CNT_W'(LENGTH - 1);
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

  state_t            state;
  logic [CNT_W-1:0]  counter;
  logic [CNT_W-1:0]  num_bits_reg;
  logic [LENGTH-1:0] seed_reg;
  logic              seed_fixed_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      counter        <= '0;
      num_bits_reg   <= '0;
      seed_reg       <= '0;
      seed_fixed_reg <= 1'b0;
    end else if (ctl.abort && state != IDLE) begin
      state   <= IDLE;
      counter <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (ctl.start && !ctl.abort) begin
            state        <= LOAD;
            counter      <= '0;
            num_bits_reg <= ctl.num_bits;
            // an all-zero seed would lock the LFSR, so force the LSB
            if (ctl.seed == '0) begin
              seed_reg       <= {{(LENGTH-1){1'b0}}, 1'b1};
              seed_fixed_reg <= 1'b1;
            end else begin
              seed_reg       <= ctl.seed;
              seed_fixed_reg <= 1'b0;
            end
          end
        end
        LOAD: begin
          // rotate so the MSB tap always holds the next bit; LENGTH rotations restore the seed
          seed_reg <= {seed_reg[LENGTH-2:0], seed_reg[LENGTH-1]};
          if (counter == LOAD_LAST) begin
            counter <= '0;
            state   <= (num_bits_reg == '0) ? DONE : RUN;
          end else begin
            counter <= counter + ONE;
          end
        end
        RUN: begin
          if (counter == num_bits_reg - ONE) begin
            counter <= '0;
            state   <= DONE;
          end else begin
            counter <= counter + ONE;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    sr_d = 1'b0;
    case (state)
      LOAD:    sr_d = seed_reg[LENGTH-1];
      RUN:     sr_d = ^(sr_state & TAPS);
      default: sr_d = 1'b0;
    endcase
  end

  assign ctl.busy       = (state != IDLE);
  assign ctl.out_valid  = (state == RUN);
  assign ctl.out_bit    = (state == RUN) & sr_state[LENGTH-1];
  assign ctl.done       = (state == DONE);
  assign ctl.seed_fixed = seed_fixed_reg;

endmodule

// File: tb/tb_lfsr_seq_ctrl.sv
// tb/tb_lfsr_seq_ctrl.sv - randomized bench for lfsr_seq_ctrl against a schedule/sequence reference model
module tb_lfsr_seq_ctrl;
  localparam int LEN = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] sr  = 8'h00;
  logic       sr_d;

  int total = 0;
  int bad   = 0;

  lfsr_seq_ctrl_if #(.LENGTH(8), .CNT_W(16)) ctl ();

  lfsr_seq_ctrl #(.LENGTH(8), .TAPS(8'hB8), .CNT_W(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .ctl      (ctl),
    .sr_state (sr),
    .sr_d     (sr_d)
  );

  always #5 clk = ~clk;

  // free-running external shift register, no enable and no reset
  always @(posedge clk) sr <= {sr[6:0], sr_d};

  // reference: a run occupies edges e=1..LEN (load), LEN+1..LEN+n (stream), LEN+1+n (done)
  logic [7:0] xs[$];
  bit         m_act   = 1'b0;
  int         m_e     = 0;
  int         m_n     = 0;
  bit         m_fixed = 1'b0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_act   <= 1'b0;
      m_e     <= 0;
      m_fixed <= 1'b0;
    end else if (m_act) begin
      if (ctl.abort || m_e >= LEN + 1 + m_n) m_act <= 1'b0;
      else m_e <= m_e + 1;
    end else if (ctl.start && !ctl.abort) begin
      m_act   <= 1'b1;
      m_e     <= 1;
      m_n     <= int'(ctl.num_bits);
      m_fixed <= (ctl.seed == 8'h00);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] lfsr_next(input logic [7:0] x);
    return {x[6:0], ^(x & 8'hB8)};
  endfunction

  task automatic chk_all();
    logic       eb, ev, ed, eo, esd;
    logic [7:0] t;
    int         e;
    eb = 0; ev = 0; ed = 0; eo = 0; esd = 0;
    e = m_e;
    if (m_act) begin
      eb = 1;
      if (e <= LEN) begin
        t   = xs[0];
        esd = t[LEN - e];
      end else if (e <= LEN + m_n) begin
        ev  = 1;
        t   = xs[e - LEN - 1];
        eo  = t[7];
        chk("sr_run", 32'(sr), 32'(t));
        t   = xs[e - LEN];
        esd = t[0];
      end else begin
        ed = 1;
        chk("sr_end", 32'(sr), 32'(xs[m_n]));
      end
    end
    chk("busy", 32'(ctl.busy), 32'(eb));
    chk("out_valid", 32'(ctl.out_valid), 32'(ev));
    chk("done", 32'(ctl.done), 32'(ed));
    chk("out_bit", 32'(ctl.out_bit), 32'(eo));
    chk("sr_d", 32'(sr_d), 32'(esd));
    chk("seed_fixed", 32'(ctl.seed_fixed), 32'(m_fixed));
  endtask

  task automatic tick(input logic st, input logic ab, input logic [7:0] sd, input logic [15:0] nb);
    logic [7:0] x;
    if (st && !ab && !m_act && rst) begin
      xs.delete();
      x = (sd == 8'h00) ? 8'h01 : sd;
      for (int i = 0; i <= int'(nb); i++) begin
        xs.push_back(x);
        x = lfsr_next(x);
      end
    end
    ctl.start    = st;
    ctl.abort    = ab;
    ctl.seed     = sd;
    ctl.num_bits = nb;
    @(negedge clk);
    chk_all();
  endtask

  task automatic idle_tick();
    tick(1'b0, 1'b0, 8'h00, 16'd0);
  endtask

  task automatic drain(input int budget);
    int k;
    k = 0;
    while (m_act && k < budget) begin
      idle_tick();
      k++;
    end
    if (m_act) chk("drain_timeout", 32'(1), 32'(0));
  endtask

  task automatic run_seed01();
    tick(1'b1, 1'b0, 8'h01, 16'd255);
    repeat (LEN) idle_tick();
    chk("first_run_sr", 32'(sr), 32'h01);
    chk("first_valid", 32'(ctl.out_valid), 32'(1));
    repeat (255) idle_tick();
    chk("wrap_sr", 32'(sr), 32'h01);
    chk("wrap_done", 32'(ctl.done), 32'(1));
    idle_tick();
    chk("after_done", 32'(ctl.busy), 32'(0));
  endtask

  initial begin
    int         nb, ab_at, gap;
    bit         plan_ab;
    logic [7:0] sd;

    ctl.start = 1'b1; ctl.abort = 1'b0; ctl.seed = 8'h5A; ctl.num_bits = 16'd3;
    repeat (3) begin
      @(negedge clk);
      chk("rst_busy", 32'(ctl.busy), 32'(0));
      chk("rst_valid", 32'(ctl.out_valid), 32'(0));
      chk("rst_sr_d", 32'(sr_d), 32'(0));
      chk("rst_fixed", 32'(ctl.seed_fixed), 32'(0));
    end
    rst = 1'b1;
    repeat (12) idle_tick();

    run_seed01();

    tick(1'b1, 1'b0, 8'h00, 16'd4);
    chk("fixed_set", 32'(ctl.seed_fixed), 32'(1));
    drain(40);
    tick(1'b1, 1'b0, 8'h80, 16'd3);
    chk("fixed_clr", 32'(ctl.seed_fixed), 32'(0));
    repeat (LEN) idle_tick();
    chk("first_bit_80", 32'(ctl.out_bit), 32'(1));
    drain(40);

    tick(1'b1, 1'b0, 8'hC3, 16'd0);
    drain(40);
    chk("zero_len_idle", 32'(ctl.busy), 32'(0));

    tick(1'b1, 1'b0, 8'h3C, 16'd20);
    while (m_act && m_e < LEN + 3) tick(1'b1, 1'b0, 8'hFF, 16'd2);
    tick(1'b0, 1'b1, 8'h00, 16'd0);
    chk("abort_valid", 32'(ctl.out_valid), 32'(0));
    chk("abort_busy", 32'(ctl.busy), 32'(0));
    tick(1'b1, 1'b1, 8'h11, 16'd5);
    chk("start_abort_idle", 32'(ctl.busy), 32'(0));
    repeat (2) idle_tick();

    tick(1'b1, 1'b0, 8'h77, 16'd30);
    while (m_act && m_e < LEN + 4) idle_tick();
    #2 rst = 1'b0;
    #1;
    chk("async_busy", 32'(ctl.busy), 32'(0));
    chk("async_valid", 32'(ctl.out_valid), 32'(0));
    chk("async_done", 32'(ctl.done), 32'(0));
    chk("async_sr_d", 32'(sr_d), 32'(0));
    @(negedge clk);
    repeat (2) idle_tick();
    rst = 1'b1;
    repeat (10) idle_tick();
    run_seed01();

    for (int r = 0; r < 40; r++) begin
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++)
        tick(1'b0, 1'($urandom_range(0, 1)), 8'($urandom), 16'($urandom));
      if ($urandom_range(0, 5) == 0) tick(1'b1, 1'b1, 8'($urandom), 16'd3);
      sd      = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      nb      = $urandom_range(0, 40);
      plan_ab = ($urandom_range(0, 3) == 0);
      ab_at   = $urandom_range(1, LEN + 1 + nb);
      tick(1'b1, 1'b0, sd, 16'(nb));
      for (int k = 0; k < 200 && m_act; k++)
        tick(1'($urandom_range(0, 3) == 0), plan_ab && (m_e == ab_at), 8'($urandom), 16'($urandom));
      if (m_act) chk("run_timeout", 32'(1), 32'(0));
    end
    drain(100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
